vga_sync_checker: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/vga_sync_checker_if.sv | 11 +
 rtl/sync_period_meter.sv | 40 ++++
 rtl/vga_sync_checker.sv | 147 ++++++++++++++
 tb/tb_vga_sync_checker.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults, checker FSM states
// and err_code bit positions shared by the VGA sync checker.
package vga_timing_pkg;

   localparam int CNT_W           = 10;

   localparam int DEF_H_TOTAL     = 800;
   localparam int DEF_H_SYNC      = 96;
   localparam int DEF_V_TOTAL     = 525;
   localparam int DEF_V_SYNC      = 2;
   localparam int DEF_LOCK_FRAMES = 2;

   localparam int ERR_LINE  = 0;
   localparam int ERR_HSYNC = 1;
   localparam int ERR_FRAME = 2;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_e;

endpackage

// File: rtl/vga_sync_checker_if.sv
// vga_sync_checker_if: active-low HSYNC/VSYNC pair on the pixel clock.
// master drives the syncs (source), slave observes them (checker).
interface vga_sync_checker_if;

   logic hsync;
   logic vsync;

   modport master (output hsync, output vsync);
   modport slave  (input hsync, input vsync);

endinterface

// File: rtl/sync_period_meter.sv
// sync_period_meter: counts ticks between falling edges of an active-low
// sync and exposes the running count plus edge strobes.
// Ports: clk, reset (sync, active high); tick (count enable);
// level (sync level, sampled on tick); cnt (ticks since last fall,
// saturating); len (cnt+1, i.e. period at fall / low width at rise);
// fall, rise (edge strobes, valid in the tick cycle).
module sync_period_meter
   import vga_timing_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             level,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] len,
   output logic             fall,
   output logic             rise
);

   logic level_r;

   // level_r idles high so a sync already low out of reset reads as an edge
   assign fall = tick & level_r & ~level;
   assign rise = tick & ~level_r & level;
   assign len  = cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         level_r <= 1'b1;
         cnt     <= '0;
      end else if (tick) begin
         level_r <= level;
         if (fall)
            cnt <= '0;
         else if (cnt != '1)
            cnt <= len;
      end
   end

endmodule

// File: rtl/vga_sync_checker.sv
// vga_sync_checker: recovers h/v position from incoming active-low syncs
// and checks line/frame timing; locks after LOCK_FRAMES clean frames.
// Ports: clk, reset (sync, active high); sync (slave: hsync, vsync);
// h_pos, v_pos (recovered position); frame_start (pulse); locked;
// timing_err (pulse) with err_code {frame/vsync, hsync width, line len};
// err_count (saturating error count, only with VGA_SYNC_ERR_CNT_EN).
module vga_sync_checker
   import vga_timing_pkg::*;
#(
   parameter int H_TOTAL     = DEF_H_TOTAL,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int V_TOTAL     = DEF_V_TOTAL,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
   input  logic              clk,
   input  logic              reset,
   vga_sync_checker_if.slave sync,
   output logic [9:0]        h_pos,
   output logic [9:0]        v_pos,
   output logic              frame_start,
   output logic              locked,
   output logic              timing_err,
   output logic [2:0]        err_code,
   output logic [15:0]       err_count
);

   localparam logic [CNT_W-1:0] HT = CNT_W'(H_TOTAL);
   localparam logic [CNT_W-1:0] HS = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] VT = CNT_W'(V_TOTAL);
   localparam logic [CNT_W-1:0] VS = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] H_STALL =
      {{(CNT_W-1){1'b1}}, 1'b0};
   localparam logic [7:0] LOCK_LAST = 8'(LOCK_FRAMES - 1);

   logic [CNT_W-1:0] h_cnt, h_len;
   logic [CNT_W-1:0] v_cnt, v_len;
   logic             hs_fall, hs_rise;
   logic             vs_fall, vs_rise;
   logic             checking, h_stall, any_err;
   logic [2:0]       err;
   state_e           state_q, state_d;
   logic [7:0]       good_q, good_d;

   sync_period_meter u_h (
      .clk   (clk),
      .reset (reset),
      .tick  (1'b1),
      .level (sync.hsync),
      .cnt   (h_cnt),
      .len   (h_len),
      .fall  (hs_fall),
      .rise  (hs_rise)
   );

   // vsync is sampled once per line, which absorbs sub-line skew
   sync_period_meter u_v (
      .clk   (clk),
      .reset (reset),
      .tick  (hs_fall),
      .level (sync.vsync),
      .cnt   (v_cnt),
      .len   (v_len),
      .fall  (vs_fall),
      .rise  (vs_rise)
   );

   assign h_pos    = h_cnt;
   assign v_pos    = v_cnt;
   assign checking = (state_q != SEARCH);

   // fires only on the step into saturation: once per stall
   assign h_stall = (h_cnt == H_STALL) & ~hs_fall;

   always_comb begin
      err = '0;
      if (checking) begin
         err[ERR_LINE]  = (hs_fall & (h_len != HT)) | h_stall;
         err[ERR_HSYNC] = hs_rise & (h_len != HS);
         err[ERR_FRAME] = (vs_fall & (v_len != VT))
                        | (vs_rise & (v_len != VS));
      end
   end

   assign any_err = |err;

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      unique case (state_q)
         SEARCH: begin
            if (vs_fall) begin
               state_d = CHECK;
               good_d  = '0;
            end
         end
         CHECK: begin
            if (any_err) begin
               state_d = SEARCH;
            end else if (vs_fall) begin
               good_d = good_q + 8'd1;
               if (good_q == LOCK_LAST)
                  state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (any_err)
               state_d = SEARCH;
         end
         default: state_d = SEARCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SEARCH;
         good_q      <= '0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         timing_err  <= 1'b0;
         err_code    <= '0;
      end else begin
         state_q     <= state_d;
         good_q      <= good_d;
         frame_start <= vs_fall;
         locked      <= (state_q == LOCKED);
         timing_err  <= any_err;
         err_code    <= err;
      end
   end

`ifdef VGA_SYNC_ERR_CNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (reset)
         err_cnt_q <= '0;
      else if (timing_err && (err_cnt_q != 16'hFFFF))
         err_cnt_q <= err_cnt_q + 16'd1;
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_checker.sv
// tb_vga_sync_checker: directed scenarios on a shrunken 40x12 raster
// with hand-computed cycle stamps for pulses and lock transitions.
module tb_vga_sync_checker;

   localparam int HT = 40;
   localparam int HS = 6;
   localparam int VT = 12;
   localparam int VS = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  h_pos, v_pos;
   logic        frame_start, locked, timing_err;
   logic [2:0]  err_code;
   logic [15:0] err_count;

   vga_sync_checker_if sif ();

   vga_sync_checker #(
      .H_TOTAL     (HT),
      .H_SYNC      (HS),
      .V_TOTAL     (VT),
      .V_SYNC      (VS),
      .LOCK_FRAMES (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sync        (sif),
      .h_pos       (h_pos),
      .v_pos       (v_pos),
      .frame_start (frame_start),
      .locked      (locked),
      .timing_err  (timing_err),
      .err_code    (err_code),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int exp_errs = 0;

   int cyc = 0;
   int err_n = 0;
   int err_cyc = 0;
   logic [2:0] err_last = '0;
   int fs_n = 0;
   int fs_cyc = 0;
   int lock_on_cyc = 0;
   int lock_off_cyc = 0;
   int hwrap_n = 0;
   int vwrap_n = 0;
   logic prev_lock = 1'b0;
   logic [9:0] prev_h = '0;
   logic [9:0] prev_v = '0;

   // event recorder, sampled 1 time unit after each rising edge
   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (timing_err) begin
         err_n++;
         err_cyc = cyc;
         err_last = err_code;
      end
      if (frame_start) begin
         fs_n++;
         fs_cyc = cyc;
      end
      if (locked && !prev_lock) lock_on_cyc = cyc;
      if (!locked && prev_lock) lock_off_cyc = cyc;
      if (h_pos == 10'd0 && prev_h == 10'(HT - 1)) hwrap_n++;
      if (v_pos == 10'd0 && prev_v == 10'(VT - 1)) vwrap_n++;
      prev_lock = locked;
      prev_h = h_pos;
      prev_v = v_pos;
   end

   task automatic step(input logic h, input logic v);
      sif.hsync = h;
      sif.vsync = v;
      @(negedge clk);
   endtask

   task automatic frame_x(input int nl, input int vsw, input int bl,
                          input int blen, input int bhw,
                          output int t_bad, output int t_aft);
      int len;
      int hw;
      t_bad = 0;
      t_aft = 0;
      for (int l = 0; l < nl; l++) begin
         len = (l == bl) ? blen : HT;
         hw = (l == bl) ? bhw : HS;
         if (l == bl) t_bad = cyc;
         if (l == bl + 1) t_aft = cyc;
         for (int i = 0; i < len; i++)
            step((i < hw) ? 1'b0 : 1'b1, (l < vsw) ? 1'b0 : 1'b1);
      end
   endtask

   task automatic frame();
      int a, b;
      frame_x(VT, VS, -1, 0, 0, a, b);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sif.hsync = 1'b1;
      sif.vsync = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (h_pos !== 10'd0) begin bad++; $display("FAIL rst_h_pos got=%0d exp=0", h_pos); end
      total++; if (v_pos !== 10'd0) begin bad++; $display("FAIL rst_v_pos got=%0d exp=0", v_pos); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%0b exp=0", locked); end
      total++; if (timing_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", timing_err); end
      total++; if (err_code !== 3'd0) begin bad++; $display("FAIL rst_code got=%0b exp=0", err_code); end
      total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs got=%0b exp=0", frame_start); end
      total++; if (err_count !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", err_count); end
      reset = 1'b0;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      total++; if (h_pos !== 10'd2) begin bad++; $display("FAIL idle_h_pos got=%0d exp=2", h_pos); end
   endtask

   task automatic test_ideal();
      int e0, f0, hw0, vw0, t3;
      e0 = err_n; f0 = fs_n; hw0 = hwrap_n; vw0 = vwrap_n;
      frame();
      frame();
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL early_lock got=%0b exp=0", locked); end
      t3 = cyc;
      frame();
      total++; if (fs_cyc != t3 + 1) begin bad++; $display("FAIL fs3_cyc got=%0d exp=%0d", fs_cyc, t3 + 1); end
      total++; if (lock_on_cyc != t3 + 2) begin bad++; $display("FAIL lock_cyc got=%0d exp=%0d", lock_on_cyc, t3 + 2); end
      frame();
      total++; if (fs_n - f0 != 4) begin bad++; $display("FAIL fs_count got=%0d exp=4", fs_n - f0); end
      total++; if (err_n != e0) begin bad++; $display("FAIL ideal_errs got=%0d exp=0", err_n - e0); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL ideal_lock got=%0b exp=1", locked); end
      total++; if (hwrap_n - hw0 != 47) begin bad++; $display("FAIL h_wraps got=%0d exp=47", hwrap_n - hw0); end
      total++; if (vwrap_n - vw0 != 3) begin bad++; $display("FAIL v_wraps got=%0d exp=3", vwrap_n - vw0); end
      total++; if (h_pos !== 10'(HT - 1)) begin bad++; $display("FAIL end_h_pos got=%0d exp=%0d", h_pos, HT - 1); end
      total++; if (v_pos !== 10'(VT - 1)) begin bad++; $display("FAIL end_v_pos got=%0d exp=%0d", v_pos, VT - 1); end
   endtask

   task automatic test_line_len();
      int e0, tb_, ta;
      e0 = err_n;
      frame_x(VT, VS, 3, HT + 1, HS, tb_, ta);
      exp_errs++;
      total++; if (err_n - e0 != 1) begin bad++; $display("FAIL len_errs got=%0d exp=1", err_n - e0); end
      total++; if (err_last !== 3'b001) begin bad++; $display("FAIL len_code got=%03b exp=001", err_last); end
      total++; if (err_cyc != ta + 1) begin bad++; $display("FAIL len_cyc got=%0d exp=%0d", err_cyc, ta + 1); end
      total++; if (lock_off_cyc != ta + 2) begin bad++; $display("FAIL len_unlock got=%0d exp=%0d", lock_off_cyc, ta + 2); end
      frame(); frame(); frame();
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL len_relock got=%0b exp=1", locked); end
      total++; if (err_n - e0 != 1) begin bad++; $display("FAIL len_relock_errs got=%0d exp=1", err_n - e0); end
   endtask

   task automatic test_hsync_width();
      int e0, tb_, ta;
      e0 = err_n;
      frame_x(VT, VS, 2, HT, HS - 1, tb_, ta);
      exp_errs++;
      total++; if (err_n - e0 != 1) begin bad++; $display("FAIL hw_errs got=%0d exp=1", err_n - e0); end
      total++; if (err_last !== 3'b010) begin bad++; $display("FAIL hw_code got=%03b exp=010", err_last); end
      total++; if (err_cyc != tb_ + HS) begin bad++; $display("FAIL hw_cyc got=%0d exp=%0d", err_cyc, tb_ + HS); end
      total++; if (lock_off_cyc != tb_ + HS + 1) begin bad++; $display("FAIL hw_unlock got=%0d exp=%0d", lock_off_cyc, tb_ + HS + 1); end
      frame(); frame(); frame();
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL hw_relock got=%0b exp=1", locked); end
   endtask

   task automatic test_frame_len();
      int e0, tb_, ta, t;
      e0 = err_n;
      frame_x(VT - 1, VS, -1, 0, 0, tb_, ta);
      total++; if (err_n != e0) begin bad++; $display("FAIL short_early got=%0d exp=0", err_n - e0); end
      t = cyc;
      frame();
      exp_errs++;
      total++; if (err_n - e0 != 1) begin bad++; $display("FAIL fl_errs got=%0d exp=1", err_n - e0); end
      total++; if (err_last !== 3'b100) begin bad++; $display("FAIL fl_code got=%03b exp=100", err_last); end
      total++; if (err_cyc != t + 1) begin bad++; $display("FAIL fl_cyc got=%0d exp=%0d", err_cyc, t + 1); end
      total++; if (fs_cyc != t + 1) begin bad++; $display("FAIL fl_fs got=%0d exp=%0d", fs_cyc, t + 1); end
      total++; if (lock_off_cyc != t + 2) begin bad++; $display("FAIL fl_unlock got=%0d exp=%0d", lock_off_cyc, t + 2); end
      frame(); frame(); frame();
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL fl_relock got=%0b exp=1", locked); end
   endtask

   task automatic test_vsync_width();
      int e0, tb_, ta;
      e0 = err_n;
      frame_x(VT, 3, 3, HT, HS, tb_, ta);
      exp_errs++;
      total++; if (err_n - e0 != 1) begin bad++; $display("FAIL vw_errs got=%0d exp=1", err_n - e0); end
      total++; if (err_last !== 3'b100) begin bad++; $display("FAIL vw_code got=%03b exp=100", err_last); end
      total++; if (err_cyc != tb_ + 1) begin bad++; $display("FAIL vw_cyc got=%0d exp=%0d", err_cyc, tb_ + 1); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL vw_lock got=%0b exp=0", locked); end
      frame(); frame(); frame();
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL vw_relock got=%0b exp=1", locked); end
   endtask

   task automatic test_timeout();
      int e0, tb_, ta;
      logic [15:0] exp_cnt;
      e0 = err_n;
      frame_x(VT, VS, VT - 1, HT, HS, tb_, ta);
      repeat (1100) step(1'b1, 1'b1);
      exp_errs++;
      total++; if (err_n - e0 != 1) begin bad++; $display("FAIL to_errs got=%0d exp=1", err_n - e0); end
      total++; if (err_last !== 3'b001) begin bad++; $display("FAIL to_code got=%03b exp=001", err_last); end
      total++; if (err_cyc != tb_ + 1024) begin bad++; $display("FAIL to_cyc got=%0d exp=%0d", err_cyc, tb_ + 1024); end
      total++; if (h_pos !== 10'd1023) begin bad++; $display("FAIL to_sat got=%0d exp=1023", h_pos); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL to_lock got=%0b exp=0", locked); end
      frame(); frame(); frame();
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL to_relock got=%0b exp=1", locked); end
      total++; if (err_n - e0 != 1) begin bad++; $display("FAIL to_relock_errs got=%0d exp=1", err_n - e0); end
`ifdef VGA_SYNC_ERR_CNT_EN
      exp_cnt = 16'(exp_errs);
`else
      exp_cnt = 16'd0;
`endif
      total++; if (err_count !== exp_cnt) begin bad++; $display("FAIL err_count got=%0d exp=%0d", err_count, exp_cnt); end
   endtask

   task automatic test_reset_mid();
      int e0, a, b;
      frame_x(6, VS, -1, 0, 0, a, b);
      for (int i = 0; i < 10; i++)
         step((i < HS) ? 1'b0 : 1'b1, 1'b1);
      reset = 1'b1;
      step(1'b1, 1'b1);
      exp_errs = 0;
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_locked got=%0b exp=0", locked); end
      total++; if (h_pos !== 10'd0) begin bad++; $display("FAIL mid_h_pos got=%0d exp=0", h_pos); end
      total++; if (v_pos !== 10'd0) begin bad++; $display("FAIL mid_v_pos got=%0d exp=0", v_pos); end
      total++; if (timing_err !== 1'b0) begin bad++; $display("FAIL mid_err got=%0b exp=0", timing_err); end
      total++; if (err_count !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", err_count); end
      reset = 1'b0;
      e0 = err_n;
      frame_x(6, 0, 0, HT - 3, HS, a, b);
      frame(); frame(); frame();
      total++; if (err_n != e0) begin bad++; $display("FAIL partial_errs got=%0d exp=0", err_n - e0); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL mid_relock got=%0b exp=1", locked); end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_line_len();
      test_hsync_width();
      test_frame_len();
      test_vsync_width();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
